// File: rtl/es_string_dest_agu.sv
// String-destination address generator: issues one ES:DI write request per element,
// steps DI by DF/size and counts CX down under REP, returning the updated DI/CX.
module es_string_dest_agu #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      es,
  input  logic [CNT_W-1:0] di_in,
  input  logic [CNT_W-1:0] cx_in,
  input  logic             rep,
  input  logic             df,
  input  logic             word,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [19:0]      addr,
  output logic             busy,
  output logic [CNT_W-1:0] di_out,
  output logic [CNT_W-1:0] cx_out,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      es_q;
  logic [CNT_W-1:0] di_q, cx_q;
  logic             rep_q, df_q, word_q;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] di_step;
  logic             last_elem;

  assign step      = word_q ? CNT_W'(2) : CNT_W'(1);
  assign di_step   = df_q ? (di_q - step) : (di_q + step);
  assign last_elem = !rep_q || (cx_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (rep && (cx_in == '0)) ? FIN : REQ;
      REQ:  if (mem_ack && last_elem) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latches: loaded on an accepted START, stepped on each acknowledged request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      es_q   <= '0;
      di_q   <= '0;
      cx_q   <= '0;
      rep_q  <= 1'b0;
      df_q   <= 1'b0;
      word_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        es_q   <= es;
        di_q   <= di_in;
        cx_q   <= cx_in;
        rep_q  <= rep;
        df_q   <= df;
        word_q <= word;
      end
    end else if ((state_q == REQ) && mem_ack) begin
      di_q <= di_step;
      if (rep_q) cx_q <= cx_q - CNT_W'(1);
    end
  end

  // All outputs decode registered state; mem_ack never reaches them combinationally.
  assign mem_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign addr    = 20'({es_q, 4'h0}) + 20'(di_q);
  assign di_out  = di_q;
  assign cx_out  = cx_q;

endmodule

// File: doc/es_string_dest_agu.md
# es_string_dest_agu

String-destination address generator for the execution unit, sitting directly downstream of the ES segment register. For STOS/MOVS-class operations it latches ES, DI and CX and issues one memory-write request per element at physical address ES:DI. It handles the bus handshake, steps DI by ±1 or ±2 according to DF and the operand size, and counts CX down under REP. Updated DI and CX are returned to the register file when the operation completes.

## Interface
- CNT_W, 16, width of DI and CX values.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a string operation; ignored unless idle.
- ES  in  16  segment value from the ES register Q output; sampled only on an accepted START.
- DI_IN  in  CNT_W  initial destination offset.
- CX_IN  in  CNT_W  initial repeat count.
- REP  in  1  1 = repeat CX times; 0 = single element.
- DF  in  1  direction: 0 = increment DI, 1 = decrement DI.
- WORD  in  1  element size: 1 = word (step 2), 0 = byte (step 1).
- MEM_ACK  in  1  bus accepted the current request this cycle.
- MEM_REQ  out  1  write request valid.
- ADDR  out  20  physical address, (ES<<4)+DI, modulo 2^20.
- BUSY  out  1  high whenever the state is not IDLE.
- DI_OUT  out  CNT_W  current/final DI.
- CX_OUT  out  CNT_W  current/final CX.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, REQ, FIN.
- **IDLE, START=1:**
  - Latch ES, DI_IN, CX_IN, REP, DF and WORD.
  - If REP=1 and CX_IN=0, go to FIN with no request issued.
  - Otherwise go to REQ.
- **REQ:**
  - MEM_REQ=1. ADDR is derived from the latched ES and the current DI.
  - MEM_ACK=0: hold all state.
  - MEM_ACK=1: DI <= DI ± step, modulo 2^CNT_W. If REP=1, CX <= CX−1.
  - After an ACK, go to FIN if REP=0 or the decremented CX is 0; otherwise stay in REQ with the new address.
- **FIN:** DONE=1 and MEM_REQ=0; go to IDLE next cycle.
- START while BUSY is ignored; no latching occurs.
- MEM_ACK outside REQ is ignored.
- The latched ES is used for the whole operation. Changes on the ES input mid-operation have no effect.
- With REP=0, CX_OUT equals CX_IN unchanged.
- Address arithmetic: {ES,4'h0} + {4'h0,DI}, truncated to 20 bits (wraps at 1 MB).
- DI wraps:
  - 0xFFFF+1 -> 0x0000
  - 0xFFFF+2 -> 0x0001
  - 0x0000−2 -> 0xFFFE
- DI_OUT and CX_OUT hold their final values in IDLE until the next accepted START.
- Reset, asserted at any time including mid-transfer:
  - State goes to IDLE immediately.
  - MEM_REQ, DONE, BUSY = 0.
  - ADDR, DI_OUT, CX_OUT, and all latched fields = 0.
  - A pending request is dropped and no DONE is issued.

## Timing
- START sampled at edge n -> BUSY=1 and MEM_REQ=1 with a valid ADDR in cycle n+1.
- Each element takes at least 1 cycle (ACK in the same cycle as the request). Back-to-back ACKs give one element per cycle.
- ACK at edge k, more elements remaining -> next ADDR, DI_OUT and CX_OUT appear in cycle k+1 with MEM_REQ still 1. There is no bubble.
- Last ACK at edge k -> DONE=1 in cycle k+1. IDLE from cycle k+2, when a new START can be accepted.
- REP with CX_IN=0: START at edge n -> DONE in cycle n+1 with no MEM_REQ. DI_OUT=DI_IN, CX_OUT=0.
- Outputs are registered or decoded from registered state only. There is no combinational path from MEM_ACK to MEM_REQ or ADDR.

## Test plan
- **Single byte:**
  - Stimulus: ES=0x1000, DI_IN=0x0020, REP=0, DF=0, WORD=0, ACK immediate.
  - Required: ADDR=0x10020 for one cycle, then DONE. DI_OUT=0x0021, CX_OUT=CX_IN.
- **REP word forward:**
  - Stimulus: ES=0x2000, DI_IN=0x0100, CX_IN=3, ACK always 1.
  - Required: ADDRs 0x20100, 0x20102, 0x20104 on consecutive cycles, DONE next cycle. DI_OUT=0x0106, CX_OUT=0.
- **Backward with wrap:**
  - Stimulus: DF=1, WORD=1, DI_IN=0x0000, CX_IN=2, REP=1.
  - Required: DI sequence 0x0000, 0xFFFE; final DI_OUT=0xFFFC.
- **Physical wrap and ACK stall:**
  - Stimulus: ES=0xFFFF, DI_IN=0x0010, REP=0, MEM_ACK held low for 3 cycles.
  - Required: ADDR=0x00000 and MEM_REQ held for 4 cycles, then DONE. START pulses during BUSY are ignored, and ES changes during BUSY do not alter ADDR.
- **REP with CX=0:**
  - Stimulus: REP=1, CX_IN=0.
  - Required: no MEM_REQ; DONE one cycle after START; DI_OUT=DI_IN.
- **Reset mid-op:**
  - Stimulus: RST low during the second element of CX=5.
  - Required: MEM_REQ, BUSY and DONE drop asynchronously; all outputs 0. After release, a fresh START runs normally.
